// File: rtl/shift_chain_pkg.sv
// Shared types and levels for the shift-chain loader.
package shift_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SHIFT_CHAIN_IDLE_LEVEL = 1'b1;
  localparam logic SHIFT_ACTIVE           = 1'b0;

endpackage

// File: rtl/shift_chain_loader.sv
// Serialises a parallel word MSB first into a daisy-chain of shift cells.
// Optional SHIFT_CHAIN_PARITY_EN appends an odd-parity bit after load_data[0].
module shift_chain_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             shift_n,
  output logic             done
);
  import shift_chain_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SHIFT_CHAIN_PARITY_EN
  localparam int unsigned LEN = WIDTH + 1;
`else
  localparam int unsigned LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN-1:0]   sreg;
  logic [LEN-1:0]   frame;

  // Bit stream as it must land in the chain; frame[LEN-1] leaves first.
`ifdef SHIFT_CHAIN_PARITY_EN
  assign frame = {load_data, ~^load_data};
`else
  assign frame = load_data;
`endif

  assign load_ready = (state == IDLE);

  // sreg holds the bits still to be sent, already advanced past the one on ser_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '1;
      shift_n <= ~SHIFT_ACTIVE;
      ser_out <= SHIFT_CHAIN_IDLE_LEVEL;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            sreg    <= {frame[LEN-2:0], SHIFT_CHAIN_IDLE_LEVEL};
            ser_out <= frame[LEN-1];
            shift_n <= SHIFT_ACTIVE;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            shift_n <= ~SHIFT_ACTIVE;
            ser_out <= SHIFT_CHAIN_IDLE_LEVEL;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            ser_out <= sreg[LEN-1];
            sreg    <= {sreg[LEN-2:0], SHIFT_CHAIN_IDLE_LEVEL};
            cnt     <= cnt + CNT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_loader.sv
// Self-checking bench for shift_chain_loader with a behavioural shift-cell chain.
// Honours SHIFT_CHAIN_PARITY_EN by lengthening the chain by one cell.
module tb_shift_chain_loader;

  localparam int unsigned WIDTH = 8;
`ifdef SHIFT_CHAIN_PARITY_EN
  localparam int unsigned LEN = WIDTH + 1;
`else
  localparam int unsigned LEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             shift_n;
  logic             done;

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;

  // Shift cells: cell 0 takes ser_out, cell i takes cell i-1; never reset.
  logic [LEN-1:0] chain = '1;

  always #5 clk = ~clk;

  shift_chain_loader #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .ser_out    (ser_out),
    .shift_n    (shift_n),
    .done       (done)
  );

  always @(posedge clk) begin
    if (shift_n == 1'b0) chain <= {chain[LEN-2:0], ser_out};
    if (done == 1'b1) done_count <= done_count + 1;
  end

  // Expected final chain contents for a word: cell i+off = data bit i, parity in cell 0.
  function automatic logic [LEN-1:0] frame_of(input logic [WIDTH-1:0] d);
`ifdef SHIFT_CHAIN_PARITY_EN
    logic par;
    par = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    return {d, par};
`else
    return d;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_shift_n"}, 32'(shift_n), 32'(1));
    chk({tag, "_ser_out"}, 32'(ser_out), 32'(1));
    chk({tag, "_ready"},   32'(load_ready), 32'(1));
    chk({tag, "_done"},    32'(done), 32'(0));
  endtask

  // Offer d in IDLE and follow it through SHIFT and DONE.
  // poke >= 0 pulses load_valid with 0x00 during that SHIFT cycle; hold keeps
  // load_valid high afterwards presenting nxt.
  task automatic run_load(input logic [WIDTH-1:0] d, input int poke,
                          input logic hold, input logic [WIDTH-1:0] nxt);
    logic [LEN-1:0] f;
    int dc0;
    f   = frame_of(d);
    dc0 = done_count;
    load_data  = d;
    load_valid = 1'b1;
    chk("ready_before", 32'(load_ready), 32'(1));
    tick;
    if (hold) load_data = nxt;
    else load_valid = 1'b0;
    for (int k = 0; k < int'(LEN); k++) begin
      if (k == poke) begin
        load_valid = 1'b1;
        load_data  = '0;
      end else if (!hold) begin
        load_valid = 1'b0;
      end
      chk("shift_n_low", 32'(shift_n), 32'(0));
      chk("ser_bit",     32'(ser_out), 32'(f[LEN-1-k]));
      chk("done_early",  32'(done), 32'(0));
      chk("ready_busy",  32'(load_ready), 32'(0));
      tick;
    end
    if (!hold) load_valid = 1'b0;
    chk("done_pulse",    32'(done), 32'(1));
    chk("done_shift_n",  32'(shift_n), 32'(1));
    chk("done_ser_out",  32'(ser_out), 32'(1));
    chk("done_ready",    32'(load_ready), 32'(0));
    chk("chain",         32'(chain), 32'(f));
    tick;
    chk("done_cleared",  32'(done), 32'(0));
    chk("ready_back",    32'(load_ready), 32'(1));
    chk("done_count",    32'(done_count), 32'(dc0 + 1));
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    logic [LEN-1:0]   f;
    int               dc0;
    int               p;

    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    #2;
    chk_idle("in_reset");
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_idle("idle");
      tick;
    end

    run_load(8'hA5, -1, 1'b0, '0);

    dc0 = done_count;
    run_load(8'h3C, -1, 1'b1, 8'hFF);
    run_load(8'hFF, -1, 1'b0, '0);
    chk("b2b_two_dones", 32'(done_count), 32'(dc0 + 2));

    run_load(8'hC3, 3, 1'b0, '0);
    tick;
    chk("poke_chain_kept", 32'(chain), 32'(frame_of(8'hC3)));
    chk_idle("after_poke");

    // Reset during the fourth SHIFT cycle of 0x5A.
    f   = frame_of(8'h5A);
    dc0 = done_count;
    load_data  = 8'h5A;
    load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("pre_rst_bit", 32'(ser_out), 32'(f[LEN-4]));
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    tick;
    rst = 1'b0;
    tick;
    tick;
    chk_idle("post_rst");
    chk("rst_no_done", 32'(done_count), 32'(dc0));
    run_load(8'h81, -1, 1'b0, '0);

    for (int n = 0; n < 10; n++) begin
      w = WIDTH'($urandom);
      p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LEN - 2)) : -1;
      run_load(w, p, 1'b0, '0);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        load_data = WIDTH'($urandom);
        chk_idle("gap");
        tick;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
